// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register: latches decode data/control, carries a valid bit,
// handles stall/flush, detects load-use hazards and counts inserted bubbles.
module idex_stage_reg #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                valid_in,
  input  logic                uses_rt,
  input  logic [DATA_W-1:0]   reg_a_data,
  input  logic [DATA_W-1:0]   reg_b_data,
  input  logic [DATA_W-1:0]   pc1,
  input  logic [DATA_W-1:0]   data_extend16,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [ALU_OP_W-1:0] alu_opc,
  input  logic                reg_dst,
  input  logic                r31,
  input  logic                reg_write,
  input  logic                alu_src,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                mem_to_reg,
  input  logic                write_pc_4,
  output logic [DATA_W-1:0]   reg_a_data_o,
  output logic [DATA_W-1:0]   reg_b_data_o,
  output logic [DATA_W-1:0]   pc1_o,
  output logic [DATA_W-1:0]   data_extend16_o,
  output logic [REG_W-1:0]    rs_o,
  output logic [REG_W-1:0]    rt_o,
  output logic [REG_W-1:0]    rd_o,
  output logic [ALU_OP_W-1:0] alu_opc_o,
  output logic                reg_dst_o,
  output logic                r31_o,
  output logic                reg_write_o,
  output logic                alu_src_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                mem_to_reg_o,
  output logic                write_pc_4_o,
  output logic                valid_o,
  output logic                hazard,
  output logic [CNT_W-1:0]    bubble_count
);

  logic bubble;

  // A load in EX whose destination is read by the instruction in ID.
  always_comb begin
    hazard = rst & valid_o & mem_read_o & valid_in & (rt_o != '0)
           & ((rt_o == rs) | (uses_rt & (rt_o == rt)));
  end

  assign bubble = flush | hazard;

  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_a_data_o    <= '0;
      reg_b_data_o    <= '0;
      pc1_o           <= '0;
      data_extend16_o <= '0;
      rs_o            <= '0;
      rt_o            <= '0;
      rd_o            <= '0;
      alu_opc_o       <= '0;
      reg_dst_o       <= 1'b0;
      r31_o           <= 1'b0;
      reg_write_o     <= 1'b0;
      alu_src_o       <= 1'b0;
      mem_read_o      <= 1'b0;
      mem_write_o     <= 1'b0;
      mem_to_reg_o    <= 1'b0;
      write_pc_4_o    <= 1'b0;
      valid_o         <= 1'b0;
      bubble_count    <= '0;
    end else if (!stall) begin
      reg_a_data_o    <= reg_a_data;
      reg_b_data_o    <= reg_b_data;
      pc1_o           <= pc1;
      data_extend16_o <= data_extend16;
      rs_o            <= rs;
      rt_o            <= rt;
      rd_o            <= rd;
      alu_opc_o       <= alu_opc;
      reg_dst_o       <= reg_dst;
      r31_o           <= r31;
      alu_src_o       <= alu_src;
      // Bubble: only state-changing controls are killed, datapath fields are don't-care.
      if (bubble) begin
        reg_write_o  <= 1'b0;
        mem_read_o   <= 1'b0;
        mem_write_o  <= 1'b0;
        mem_to_reg_o <= 1'b0;
        write_pc_4_o <= 1'b0;
        valid_o      <= 1'b0;
        if (bubble_count != {CNT_W{1'b1}})
          bubble_count <= bubble_count + CNT_W'(1);
      end else begin
        reg_write_o  <= reg_write;
        mem_read_o   <= mem_read;
        mem_write_o  <= mem_write;
        mem_to_reg_o <= mem_to_reg;
        write_pc_4_o <= write_pc_4;
        valid_o      <= valid_in;
      end
    end
  end

endmodule

// File: tb/tb_idex_stage_reg.sv
// Self-checking bench for idex_stage_reg: directed scenarios plus randomized
// traffic against a cycle-level reference model of the stage.
module tb_idex_stage_reg;

  typedef struct packed {
    logic [31:0] a, b, pc1, ext;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  alu;
    logic reg_dst, r31, reg_write, alu_src, mem_read, mem_write, mem_to_reg, write_pc_4;
  } fields_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall, flush, valid_in, uses_rt;
  fields_t fin;

  logic [31:0] o_a, o_b, o_pc1, o_ext;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [2:0]  o_alu;
  logic o_reg_dst, o_r31, o_reg_write, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg, o_write_pc_4;
  logic valid_o, hazard;
  logic [15:0] bubble_count;

  logic [31:0] s_a, s_b, s_pc1, s_ext;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [2:0]  s_alu;
  logic s_reg_dst, s_r31, s_reg_write, s_alu_src, s_mem_read, s_mem_write, s_mem_to_reg, s_write_pc_4;
  logic s_valid_o, s_hazard;
  logic [1:0] s_bubble_count;

  fields_t fout, sout;
  assign fout = {o_a, o_b, o_pc1, o_ext, o_rs, o_rt, o_rd, o_alu, o_reg_dst, o_r31,
                 o_reg_write, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg, o_write_pc_4};
  assign sout = {s_a, s_b, s_pc1, s_ext, s_rs, s_rt, s_rd, s_alu, s_reg_dst, s_r31,
                 s_reg_write, s_alu_src, s_mem_read, s_mem_write, s_mem_to_reg, s_write_pc_4};

  idex_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in), .uses_rt(uses_rt),
    .reg_a_data(fin.a), .reg_b_data(fin.b), .pc1(fin.pc1), .data_extend16(fin.ext),
    .rs(fin.rs), .rt(fin.rt), .rd(fin.rd), .alu_opc(fin.alu),
    .reg_dst(fin.reg_dst), .r31(fin.r31), .reg_write(fin.reg_write), .alu_src(fin.alu_src),
    .mem_read(fin.mem_read), .mem_write(fin.mem_write), .mem_to_reg(fin.mem_to_reg),
    .write_pc_4(fin.write_pc_4),
    .reg_a_data_o(o_a), .reg_b_data_o(o_b), .pc1_o(o_pc1), .data_extend16_o(o_ext),
    .rs_o(o_rs), .rt_o(o_rt), .rd_o(o_rd), .alu_opc_o(o_alu),
    .reg_dst_o(o_reg_dst), .r31_o(o_r31), .reg_write_o(o_reg_write), .alu_src_o(o_alu_src),
    .mem_read_o(o_mem_read), .mem_write_o(o_mem_write), .mem_to_reg_o(o_mem_to_reg),
    .write_pc_4_o(o_write_pc_4),
    .valid_o(valid_o), .hazard(hazard), .bubble_count(bubble_count)
  );

  idex_stage_reg #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in), .uses_rt(uses_rt),
    .reg_a_data(fin.a), .reg_b_data(fin.b), .pc1(fin.pc1), .data_extend16(fin.ext),
    .rs(fin.rs), .rt(fin.rt), .rd(fin.rd), .alu_opc(fin.alu),
    .reg_dst(fin.reg_dst), .r31(fin.r31), .reg_write(fin.reg_write), .alu_src(fin.alu_src),
    .mem_read(fin.mem_read), .mem_write(fin.mem_write), .mem_to_reg(fin.mem_to_reg),
    .write_pc_4(fin.write_pc_4),
    .reg_a_data_o(s_a), .reg_b_data_o(s_b), .pc1_o(s_pc1), .data_extend16_o(s_ext),
    .rs_o(s_rs), .rt_o(s_rt), .rd_o(s_rd), .alu_opc_o(s_alu),
    .reg_dst_o(s_reg_dst), .r31_o(s_r31), .reg_write_o(s_reg_write), .alu_src_o(s_alu_src),
    .mem_read_o(s_mem_read), .mem_write_o(s_mem_write), .mem_to_reg_o(s_mem_to_reg),
    .write_pc_4_o(s_write_pc_4),
    .valid_o(s_valid_o), .hazard(s_hazard), .bubble_count(s_bubble_count)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: what the stage should hold after the last edge.
  fields_t exp_f;
  logic    exp_v;
  int      exp_c, exp_c2;

  function automatic logic model_hazard();
    return rst && exp_v && exp_f.mem_read && valid_in && (exp_f.rt != 5'd0) &&
           ((exp_f.rt == fin.rs) || (uses_rt && (exp_f.rt == fin.rt)));
  endfunction

  function automatic fields_t rand_fields(input bit clean);
    fields_t f;
    f.a = $urandom; f.b = $urandom; f.pc1 = $urandom; f.ext = $urandom;
    f.rs = 5'($urandom_range(0, 3)); f.rt = 5'($urandom_range(0, 3)); f.rd = 5'($urandom);
    f.alu = 3'($urandom);
    f.reg_dst = 1'($urandom); f.r31 = 1'($urandom); f.reg_write = 1'($urandom);
    f.alu_src = 1'($urandom); f.mem_read = clean ? 1'b0 : 1'($urandom);
    f.mem_write = 1'($urandom); f.mem_to_reg = 1'($urandom); f.write_pc_4 = 1'($urandom);
    return f;
  endfunction

  // Advance the model with the currently driven inputs, then take the clock edge.
  task automatic tick();
    fields_t n;
    logic nv, hz;
    int nc, nc2;
    hz = model_hazard();
    n = exp_f; nv = exp_v; nc = exp_c; nc2 = exp_c2;
    if (!rst) begin
      n = '0; nv = 1'b0; nc = 0; nc2 = 0;
    end else if (!stall) begin
      n = fin;
      nv = valid_in;
      if (flush || hz) begin
        nv = 1'b0;
        n.reg_write = 1'b0; n.mem_read = 1'b0; n.mem_write = 1'b0;
        n.write_pc_4 = 1'b0; n.mem_to_reg = 1'b0;
        nc  = (nc  < 65535) ? nc + 1  : nc;
        nc2 = (nc2 < 3)     ? nc2 + 1 : nc2;
      end
    end
    @(posedge clk);
    exp_f = n; exp_v = nv; exp_c = nc; exp_c2 = nc2;
    #1;
  endtask

  task automatic test_reset();
    fields_t applied;
    rst = 1'b0; stall = 1'b1; flush = 1'b1; valid_in = 1'b1; uses_rt = 1'b1; fin = '1;
    exp_f = '0; exp_v = 1'b0; exp_c = 0; exp_c2 = 0;
    tick(); tick();
    checks++; if (fout !== '0) begin failures++; $display("FAIL reset_fields got=%h want=0", fout); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    checks++; if (bubble_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", bubble_count); end
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%b want=0", hazard); end
    rst = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b1; uses_rt = 1'b0;
    applied = rand_fields(1'b0);
    fin = applied;
    #1;
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL release_hazard got=%b want=0", hazard); end
    tick();
    checks++; if (fout !== applied) begin failures++; $display("FAIL first_instr got=%h want=%h", fout, applied); end
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL first_valid got=%b want=1", valid_o); end
  endtask

  task automatic test_pass_through();
    fin = rand_fields(1'b1); valid_in = 1'b1; tick();
    fin = rand_fields(1'b1);
    fin.a = 32'hDEAD_BEEF; fin.rs = 5'd3; fin.alu = 3'b101; fin.reg_write = 1'b1;
    valid_in = 1'b1;
    tick();
    checks++; if (o_a !== 32'hDEAD_BEEF) begin failures++; $display("FAIL pass_a got=%h want=deadbeef", o_a); end
    checks++; if (o_rs !== 5'd3) begin failures++; $display("FAIL pass_rs got=%0d want=3", o_rs); end
    checks++; if (o_alu !== 3'd5) begin failures++; $display("FAIL pass_alu got=%0d want=5", o_alu); end
    checks++; if (o_reg_write !== 1'b1) begin failures++; $display("FAIL pass_reg_write got=%b want=1", o_reg_write); end
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL pass_valid got=%b want=1", valid_o); end
  endtask

  task automatic test_load_use();
    int c0;
    fin = rand_fields(1'b1); fin.rt = 5'd8; fin.mem_read = 1'b1; valid_in = 1'b1; uses_rt = 1'b0;
    tick();
    c0 = exp_c;
    fin = rand_fields(1'b1); fin.rs = 5'd8; fin.rt = 5'd2;
    #1;
    checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL lu_hazard got=%b want=1", hazard); end
    tick();
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL lu_valid got=%b want=0", valid_o); end
    checks++; if (o_mem_read !== 1'b0) begin failures++; $display("FAIL lu_mem_read got=%b want=0", o_mem_read); end
    checks++; if (bubble_count !== 16'(c0 + 1)) begin failures++; $display("FAIL lu_count got=%0d want=%0d", bubble_count, c0 + 1); end
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL lu_hazard_clear got=%b want=0", hazard); end
  endtask

  task automatic test_no_false_hazard();
    fin = rand_fields(1'b1); fin.rt = 5'd0; fin.mem_read = 1'b1; valid_in = 1'b1;
    tick();
    fin = rand_fields(1'b1); fin.rs = 5'd0; fin.rt = 5'd0; uses_rt = 1'b1;
    #1;
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL rt_zero_hazard got=%b want=0", hazard); end
    tick();
    fin = rand_fields(1'b1); fin.rt = 5'd9; fin.mem_read = 1'b1;
    tick();
    fin = rand_fields(1'b1); fin.rs = 5'd1; fin.rt = 5'd9; uses_rt = 1'b0;
    #1;
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL rt_unused_hazard got=%b want=0", hazard); end
    uses_rt = 1'b1;
    #1;
    checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL rt_used_hazard got=%b want=1", hazard); end
    rst = 1'b0;
    #1;
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL hazard_in_reset got=%b want=0", hazard); end
    tick();
    checks++; if (valid_o !== 1'b0 || bubble_count !== 16'd0 || fout !== '0) begin
      failures++; $display("FAIL reset_mid_hazard got=v%b c%0d f%h want=v0 c0 f0", valid_o, bubble_count, fout);
    end
    rst = 1'b1; uses_rt = 1'b0;
  endtask

  task automatic test_stall();
    fields_t held;
    int c0;
    stall = 1'b0; flush = 1'b0;
    held = rand_fields(1'b1); held.rt = 5'd8; held.mem_read = 1'b1;
    fin = held; valid_in = 1'b1;
    tick();
    c0 = exp_c;
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; flush = 1'($urandom);
      fin = rand_fields(1'b0); fin.rs = 5'd8; valid_in = 1'b1;
      #1;
      checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL stall_hazard[%0d] got=%b want=1", i, hazard); end
      tick();
      checks++; if (fout !== held || valid_o !== 1'b1 || bubble_count !== 16'(c0)) begin
        failures++; $display("FAIL stall_hold[%0d] got=%h v%b c%0d want=%h v1 c%0d", i, fout, valid_o, bubble_count, held, c0);
      end
    end
    stall = 1'b0; flush = 1'b0;
    tick();
    checks++; if (valid_o !== 1'b0 || bubble_count !== 16'(c0 + 1)) begin
      failures++; $display("FAIL stall_release got=v%b c%0d want=v0 c%0d", valid_o, bubble_count, c0 + 1);
    end
  endtask

  task automatic test_flush_hazard();
    int c0;
    fin = rand_fields(1'b1); fin.rt = 5'd8; fin.mem_read = 1'b1; valid_in = 1'b1;
    tick();
    c0 = exp_c;
    fin = rand_fields(1'b1); fin.rs = 5'd8; flush = 1'b1;
    #1;
    checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL fh_hazard got=%b want=1", hazard); end
    tick();
    checks++; if (bubble_count !== 16'(c0 + 1) || valid_o !== 1'b0) begin
      failures++; $display("FAIL fh_single_bubble got=c%0d v%b want=c%0d v0", bubble_count, valid_o, c0 + 1);
    end
    flush = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    rst = 1'b1; flush = 1'b1; valid_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      fin = rand_fields(1'b0);
      tick();
      checks++; if (s_bubble_count !== 2'((k < 3) ? k : 3)) begin
        failures++; $display("FAIL sat_small[%0d] got=%0d want=%0d", k, s_bubble_count, (k < 3) ? k : 3);
      end
      checks++; if (bubble_count !== 16'(k)) begin failures++; $display("FAIL sat_wide[%0d] got=%0d want=%0d", k, bubble_count, k); end
    end
    flush = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      fin = rand_fields(1'b0);
      valid_in = ($urandom_range(0, 9) < 8);
      uses_rt = 1'($urandom);
      stall = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 9) < 1);
      rst = ($urandom_range(0, 99) >= 3);
      #1;
      checks++; if (hazard !== model_hazard() || s_hazard !== model_hazard()) begin
        failures++; $display("FAIL rnd_hazard[%0d] got=%b/%b want=%b", i, hazard, s_hazard, model_hazard());
      end
      tick();
      checks++; if (fout !== exp_f || sout !== exp_f) begin
        failures++; $display("FAIL rnd_fields[%0d] got=%h small=%h want=%h", i, fout, sout, exp_f);
      end
      checks++; if (valid_o !== exp_v || s_valid_o !== exp_v) begin
        failures++; $display("FAIL rnd_valid[%0d] got=%b/%b want=%b", i, valid_o, s_valid_o, exp_v);
      end
      checks++; if (bubble_count !== 16'(exp_c) || s_bubble_count !== 2'(exp_c2)) begin
        failures++; $display("FAIL rnd_count[%0d] got=%0d/%0d want=%0d/%0d", i, bubble_count, s_bubble_count, exp_c, exp_c2);
      end
    end
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_false_hazard();
    test_stall();
    test_flush_hazard();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
